// File: rtl/ethernet_mdio_link_monitor.sv
// Clause-22 MDIO master: polls the PHY BMSR and publishes link and error status.
// Latency: 64 slots of 2*MDC_HALF_PERIOD cycles, then 1 UPDATE cycle; next poll POLL_INTERVAL cycles later.
// Backpressure: none; free-running poller gated only by phy_ready_i, which aborts any frame in flight.
module ethernet_mdio_link_monitor #(
    parameter int         MDC_HALF_PERIOD = 20,
    parameter logic [4:0] PHY_ADDR        = 5'b00001,
    parameter int         POLL_INTERVAL   = 100000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        phy_ready_i,
    output logic        mdc_o,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    output logic [15:0] bmsr_o,
    output logic        link_up_o,
    output logic        error_o,
    output logic        poll_done_o
);

    typedef enum logic [1:0] {
        WAIT_READY,
        FRAME,
        UPDATE,
        IDLE
    } state_t;

    typedef struct packed {
        logic [15:0] bmsr;
        logic        link_up;
        logic        error;
    } status_t;

    localparam int SLOT_LEN = 2 * MDC_HALF_PERIOD;
    localparam int PH_W     = $clog2(SLOT_LEN);
    localparam int IV_W     = $clog2(POLL_INTERVAL + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_LEN - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(MDC_HALF_PERIOD);
    localparam logic [IV_W-1:0] IV_LAST = IV_W'(POLL_INTERVAL - 1);

    localparam logic [5:0] SLOT_HDR0  = 6'd32;
    localparam logic [5:0] SLOT_RX    = 6'd46;
    localparam logic [5:0] SLOT_TA    = 6'd47;
    localparam logic [5:0] SLOT_DATA0 = 6'd48;
    localparam logic [5:0] SLOT_LAST  = 6'd63;

    // ST(01), OP read(10), PHY address, REGAD=1 (BMSR); sent MSB first from slot 32
    localparam logic [13:0] HDR = {2'b01, 2'b10, PHY_ADDR, 5'd1};

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [5:0]        slot_q, slot_d;
    logic [IV_W-1:0]   ivl_q, ivl_d;
    logic [15:0]       shift_q, shift_d;
    logic              ta_q, ta_d;
    status_t           stat_q, stat_d;
    logic              mdc_q, mdc_d;
    logic              mdio_q, mdio_d;
    logic              oe_q, oe_d;
    logic              done_q, done_d;
    logic              slot_end;
    logic [3:0]        hdr_idx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WAIT_READY;
            phase_q <= '0;
            slot_q  <= '0;
            ivl_q   <= '0;
            shift_q <= '0;
            ta_q    <= 1'b1;
            stat_q  <= '0;
            mdc_q   <= 1'b0;
            mdio_q  <= 1'b1;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
            ivl_q   <= ivl_d;
            shift_q <= shift_d;
            ta_q    <= ta_d;
            stat_q  <= stat_d;
            mdc_q   <= mdc_d;
            mdio_q  <= mdio_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        slot_d   = slot_q;
        ivl_d    = ivl_q;
        shift_d  = shift_q;
        ta_d     = ta_q;
        stat_d   = stat_q;
        hdr_idx  = '0;
        slot_end = (phase_q == PH_LAST);

        if (!phy_ready_i) begin
            // PHY went back into reset: drop the frame, keep last BMSR/error
            state_d        = WAIT_READY;
            phase_d        = '0;
            slot_d         = '0;
            ivl_d          = '0;
            stat_d.link_up = 1'b0;
        end else begin
            case (state_q)
                WAIT_READY: begin
                    state_d = FRAME;
                    phase_d = '0;
                    slot_d  = '0;
                end
                FRAME: begin
                    if (slot_end) begin
                        // slot_end is the last cycle of the MDC high half: sample point
                        phase_d = '0;
                        if (slot_q == SLOT_TA) begin
                            ta_d = mdio_i;
                        end
                        if (slot_q >= SLOT_DATA0) begin
                            shift_d = {shift_q[14:0], mdio_i};
                        end
                        if (slot_q == SLOT_LAST) begin
                            state_d = UPDATE;
                            slot_d  = '0;
                            // status is published together with poll_done_o
                            if (!ta_q) begin
                                stat_d.bmsr    = shift_d;
                                stat_d.link_up = shift_d[2];
                                stat_d.error   = 1'b0;
                            end else begin
                                stat_d.link_up = 1'b0;
                                stat_d.error   = 1'b1;
                            end
                        end else begin
                            slot_d = slot_q + 6'd1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                UPDATE: begin
                    state_d = IDLE;
                    ivl_d   = '0;
                end
                IDLE: begin
                    if (ivl_q == IV_LAST) begin
                        state_d = FRAME;
                        phase_d = '0;
                        slot_d  = '0;
                    end else begin
                        ivl_d = ivl_q + 1'b1;
                    end
                end
                default: state_d = WAIT_READY;
            endcase
        end

        // Pin outputs are registered from next-state values so they stay glitch-free
        mdc_d  = (state_d == FRAME) && (phase_d >= PH_HIGH);
        oe_d   = (state_d == FRAME) && (slot_d < SLOT_RX);
        mdio_d = 1'b1;
        if ((state_d == FRAME) && (slot_d >= SLOT_HDR0) && (slot_d < SLOT_RX)) begin
            hdr_idx = 4'(SLOT_RX - 6'd1 - slot_d);
            mdio_d  = HDR[hdr_idx];
        end
        done_d = (state_d == UPDATE);
    end

    assign mdc_o       = mdc_q;
    assign mdio_o      = mdio_q;
    assign mdio_oe_o   = oe_q;
    assign bmsr_o      = stat_q.bmsr;
    assign link_up_o   = stat_q.link_up;
    assign error_o     = stat_q.error;
    assign poll_done_o = done_q;

endmodule

// File: tb/tb_ethernet_mdio_link_monitor.sv
// Bench for ethernet_mdio_link_monitor: PHY model on the MDIO pins plus a poll_done scoreboard.
`timescale 1ns/1ps
module tb_ethernet_mdio_link_monitor;

    localparam int HP = 20;
    localparam int PI = 200;
    localparam logic [45:0] EXP_HDR = {32'hFFFF_FFFF, 14'b01_10_00001_00001};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phy_ready = 1'b0;
    logic        mdio_i = 1'b1;
    logic        mdc_o, mdio_o, mdio_oe_o, link_up_o, error_o, poll_done_o;
    logic [15:0] bmsr_o;

    ethernet_mdio_link_monitor #(
        .MDC_HALF_PERIOD(HP),
        .PHY_ADDR       (5'b00001),
        .POLL_INTERVAL  (PI)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .phy_ready_i(phy_ready),
        .mdc_o      (mdc_o),
        .mdio_i     (mdio_i),
        .mdio_o     (mdio_o),
        .mdio_oe_o  (mdio_oe_o),
        .bmsr_o     (bmsr_o),
        .link_up_o  (link_up_o),
        .error_o    (error_o),
        .poll_done_o(poll_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bmsr;
        logic        link;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          phy_slot = -1;
    int          rise_cnt = 0;
    int          total_mdc = 0;
    logic [15:0] phy_data = 16'h786D;
    logic        phy_present = 1'b1;
    logic [45:0] cap = '0;
    logic        oe_ok = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // PHY model: slot index restarts when the master starts driving a new frame
    always @(posedge mdio_oe_o) rise_cnt = 0;

    always @(posedge mdc_o) begin
        total_mdc++;
        phy_slot = rise_cnt;
        rise_cnt++;
        if (phy_slot == 0) oe_ok = 1'b1;
        if (phy_slot < 46) begin
            cap   = {cap[44:0], mdio_o};
            oe_ok = oe_ok & mdio_oe_o;
        end
        if (phy_slot == 46) begin
            chk("frame_bits", 64'(cap), 64'(EXP_HDR));
            chk("oe_drop_slot46", {oe_ok, mdio_oe_o}, 2'b10);
        end
        if (phy_slot == 47)
            mdio_i = !phy_present;
        else if (phy_slot >= 48 && phy_slot <= 63 && phy_present)
            mdio_i = phy_data[63 - phy_slot];
        else
            mdio_i = 1'b1;
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && poll_done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_poll_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    chk("poll_done_width", poll_done_o, 1'b0);
                    chk("bmsr", bmsr_o, e.bmsr);
                    chk("link_up", link_up_o, e.link);
                    chk("error", error_o, e.err);
                    done_cnt++;
                end
            end
        end
    end

    task automatic wait_done(input int n, input int bound);
        for (int i = 0; i < bound && done_cnt < n; i++) @(negedge clk);
        chk("frames_done", done_cnt, n);
    endtask

    task automatic wait_slot(input int s, input int bound);
        for (int i = 0; i < bound && phy_slot != s; i++) @(negedge clk);
        chk("reached_slot", phy_slot, s);
    endtask

    initial begin
        int w;
        int cnt;
        int gap;

        repeat (5) @(negedge clk);
        chk("rst_pins", {mdc_o, mdio_oe_o, mdio_o}, 3'b001);
        chk("rst_status", {bmsr_o, link_up_o, error_o, poll_done_o}, 19'd0);
        rst_n = 1'b1;

        repeat (1000) @(negedge clk);
        chk("no_mdc_while_not_ready", total_mdc, 0);
        chk("wait_ready_outputs", {mdc_o, mdio_oe_o, link_up_o, poll_done_o}, 4'b0000);

        // Frame 1: good read, link up
        phy_data = 16'h786D;
        phy_present = 1'b1;
        exp_q.push_back('{16'h786D, 1'b1, 1'b0});
        phy_ready = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!mdio_oe_o && w < 50);
        cnt = 1;
        while (!poll_done_o && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        chk("frame_latency", cnt, 2561);

        // Frame 2: link bit clear; measure the idle gap
        phy_data = 16'h7869;
        exp_q.push_back('{16'h7869, 1'b0, 1'b0});
        gap = 0;
        @(negedge clk);
        while (!mdio_oe_o && gap < PI + 50) begin
            gap++;
            @(negedge clk);
        end
        chk("poll_gap", gap, PI);
        wait_done(2, 4000);

        // Frame 3: PHY absent, mdio stuck high
        phy_present = 1'b0;
        exp_q.push_back('{16'h7869, 1'b0, 1'b1});
        wait_done(3, 4000);

        // Frame 4: good read clears the error
        phy_present = 1'b1;
        phy_data = 16'h786D;
        exp_q.push_back('{16'h786D, 1'b1, 1'b0});
        wait_done(4, 4000);

        // Frame 5: aborted at slot 50
        wait_slot(50, 4000);
        phy_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pins", {mdc_o, mdio_oe_o, link_up_o}, 3'b000);
        chk("abort_hold", {bmsr_o, error_o}, {16'h786D, 1'b0});
        repeat (100) @(negedge clk);
        chk("no_done_after_abort", done_cnt, 4);
        chk("abort_idle_pins", {mdc_o, mdio_oe_o, poll_done_o}, 3'b000);

        // Frame 6: restart from slot 0
        phy_data = 16'h7809;
        exp_q.push_back('{16'h7809, 1'b0, 1'b0});
        phy_ready = 1'b1;
        wait_done(5, 4000);

        // Frame 7: async reset during slot 20
        wait_slot(20, 4000);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pins", {mdc_o, mdio_oe_o, mdio_o}, 3'b001);
        chk("async_rst_status", {bmsr_o, link_up_o, error_o, poll_done_o}, 19'd0);
        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ethernet_mdio_link_monitor.md
Name: ethernet_mdio_link_monitor

Overview:
MDIO management master that reads the PHY once the PHY reset generator releases it. It issues periodic Clause-22 read frames of the Basic Mode Status Register (BMSR, reg 1). It publishes the last BMSR value, the link-up status and a no-response error to the Ethernet MAC and to the SoC status logic. It sits between the PHY reset generator output (phy_ready_i) and the external MDC/MDIO pins; the tristate buffer is at top level.

Parameters:
MDC_HALF_PERIOD, 20, clk_i cycles per MDC half period (100 MHz -> 2.5 MHz MDC); must be >= 2
PHY_ADDR, 5'b00001, PHY address sent in every frame
POLL_INTERVAL, 100000, clk_i cycles from the end of one frame to the start of the next (1 ms at 100 MHz)

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
phy_ready_i  input  1  high when PHY reset is released (reset generator output)
mdc_o  output  1  management clock to PHY
mdio_i  input  1  MDIO pin value (sampled)
mdio_o  output  1  MDIO drive value
mdio_oe_o  output  1  1 = master drives MDIO
bmsr_o  output  16  last successfully read BMSR
link_up_o  output  1  bmsr_o[2] of the last good read
error_o  output  1  last frame had no PHY response
poll_done_o  output  1  one-cycle pulse at the end of every completed frame

Behaviour:
- Single clock domain. Async active-low reset. Reset values: mdc_o=0, mdio_o=1, mdio_oe_o=0, bmsr_o=0, link_up_o=0, error_o=0, poll_done_o=0, FSM=WAIT_READY.
- FSM states: WAIT_READY, FRAME, UPDATE, IDLE.
- WAIT_READY: outputs held at reset values, except bmsr_o and error_o, which hold. On phy_ready_i=1, go to FRAME on the next cycle.
- Frame = 64 bit slots, numbered 0..63. Each slot = 2*MDC_HALF_PERIOD clk_i cycles: first half mdc_o=0, second half mdc_o=1. mdio_o changes only at slot start, i.e. while MDC is low.
- Slots 0-31: preamble, mdio_o=1, oe=1.
- Slots 32-33: ST = 0,1.
- Slots 34-35: OP = 1,0 (read).
- Slots 36-40: PHY_ADDR, MSB first.
- Slots 41-45: REGAD = 5'd1, MSB first.
- Slots 46-63: mdio_oe_o=0 and mdio_o=1.
- Sampling: mdio_i is sampled on the last clk_i cycle of each slot's high half.
  - Slot 47 (TA second bit): expect 0.
  - Slots 48-63: shifted MSB first into a 16-bit shift register.
- After slot 63 ends, mdc_o=0 and the FSM goes to UPDATE for exactly one cycle.
- UPDATE, TA sample = 0: bmsr_o <= shift register, link_up_o <= shift[2], error_o <= 0.
- UPDATE, TA sample = 1 (no PHY, pull-up): bmsr_o unchanged, link_up_o <= 0, error_o <= 1.
- UPDATE, either case: poll_done_o=1 for this cycle only, then go to IDLE.
- Full frame length: 64*2*MDC_HALF_PERIOD cycles (2560 at defaults), plus 1 UPDATE cycle.
- IDLE: count POLL_INTERVAL cycles with mdc_o=0, oe=0, then go to FRAME.
- Counters: MDC phase counter, 6-bit slot counter (wraps only via FRAME exit), and interval counter sized by $clog2(POLL_INTERVAL+1).
- phy_ready_i=0 in any state, taking priority: go to WAIT_READY next cycle.
  - The frame is aborted with no UPDATE and no poll_done_o.
  - mdc_o=0, oe=0 and link_up_o=0 immediately on the next cycle.
  - bmsr_o and error_o hold.
- phy_ready_i re-asserted: a fresh frame starts from slot 0.
- rst_n_i asserted mid-frame: all state goes to reset values immediately (asynchronous).
- BMSR bit 2 is latching-low in the PHY. The block reports the raw read value and does no double-read.

Test Plan:
- Reset with phy_ready_i=0 for 1000 cycles -> mdc_o=0, mdio_oe_o=0, link_up_o=0, no poll_done_o.
- Raise phy_ready_i; PHY model answers TA=0 and data 16'h786D. The bench must check:
  - 32 ones are driven, then 0110 00001 00001.
  - oe drops at slot 46.
  - poll_done_o pulses 2561 cycles after FRAME entry.
  - bmsr_o=16'h786D and link_up_o=1.
- PHY model returns 16'h7869 on the next poll -> the second frame starts POLL_INTERVAL cycles after UPDATE; link_up_o=0, bmsr_o=16'h7869, error_o=0.
- PHY absent (mdio_i stuck 1) -> error_o=1, link_up_o=0, bmsr_o keeps its previous value; a later good read clears error_o.
- Drop phy_ready_i at slot 50 -> no poll_done_o; next cycle mdc_o=0, oe=0, link_up_o=0. Re-raise it -> a new frame starts with preamble slot 0.
- Assert rst_n_i during slot 20 -> all outputs take their reset values asynchronously, before the next clk_i edge.
